mandel_mmio_engine: RTL
=======================

// Module: mandel_mmio_engine
// PURPOSE
// Memory-mapped Mandelbrot iteration engine sitting directly downstream of the single-cycle CPU datapath's data port.
// CPU stores cx, cy and max_iter, writes START, polls STATUS, then loads the escape count.
// One z = z^2 + c iteration per clock, in signed fixed point.
// Top level muxes rdata into the datapath's readmem whenever hit=1.
// PARAMETERS
// BASE_ADDR  32'hFFFF_0000  base byte address; the block decodes 32 bytes
// FRAC       28             fraction bits of signed Q(32-FRAC).FRAC operands (default Q4.28)
// ITER_W     16             width of max_iter and the iteration counter
// PORTS
// clk       in   1       system clock; all state on posedge
// reset     in   1       synchronous, active-high
// memaddr   in   32      byte address from datapath ALU
// writedata in   32      store data from datapath
// memwrite  in   1       store strobe, sampled on posedge clk
// hit       out  1       memaddr[31:5]==BASE_ADDR[31:5]; combinational
// rdata     out  32      combinational read data; 0 when hit=0
// busy      out  1       engine iterating (mirrors STATUS[0])
// BEHAVIOUR
// Register map (offset = memaddr[4:2]; memaddr[1:0] ignored):
// - 0 CX (R/W, 32b). 1 CY (R/W, 32b). 2 MAXITER (R/W, low ITER_W bits; upper bits read 0).
// - 3 CTRL/STATUS: write bit0=1 -> START. Read {30'b0, done, busy}.
// - 4 ITER (RO, zero-extended result). Offsets 5-7 read 0; writes to them are ignored.
// Reset: CX=CY=MAXITER=ITER=0; zr=zi=count=0; busy=0; done=0; state IDLE.
// Writes take effect on the posedge where memwrite=1 and hit=1. Reads are same-cycle combinational.
// FSM IDLE -> ITER -> IDLE.
// - IDLE: START latches CX/CY/MAXITER into working copies.
//   Clears zr, zi, count and done; sets busy. Goes to ITER next edge.
// - ITER (one clock each): sr=(zr*zr)>>>FRAC, si=(zi*zi)>>>FRAC, computed from full 64-bit signed products.
// - If sr+si > 4.0 (compared at 34+ bits, no overflow): ITER=count, done=1, busy=0 -> IDLE.
// - Else if count==max_iter: ITER=max_iter, done=1, busy=0 -> IDLE.
// - Else: zr<=sr-si+cx; zi<=((2*zr*zi)>>>FRAC)+cy; count<=count+1.
// Escape test is strict '>': |z|^2 == 4.0 does not escape.
// Latency: START edge T, done visible after edge T+1+N, where N = final ITER value (N+1 ITER cycles).
// Boundaries:
// - START while busy: ignored.
// - CX/CY/MAXITER writes while busy: update the registers; the running job keeps its latched copies.
// - max_iter=0: done after one ITER cycle with ITER=0.
// - |cx| or |cy| >= 4.0: z may wrap; result unspecified, but the job still terminates within max_iter+1 cycles.
// - reset mid-job: returns to the reset state next edge; no result is written.
// - ITER holds the previous result until the next job completes. done stays set until the next START.
// TESTING
// 1. Reset, read all 8 offsets -> all 0; hit=0 for BASE_ADDR+32 and BASE_ADDR-4.
// 2. CX=0x1000_0000 (1.0), CY=0, MAXITER=100, START -> busy for 4 cycles, then done=1, ITER=3.
// 3. CX=0x2000_0000 (2.0), MAXITER=100 -> ITER=2. CX=0xE000_0000 (-2.0) -> |z|^2==4 exactly, never escapes, ITER=100.
// 4. CX=CY=0, MAXITER=0 -> ITER=0 after 1 ITER cycle. MAXITER=0xFFFF, c=0 -> ITER=65535.
// 5. During a job: write CX=2.0 and write START again -> job unaffected (ITER=3 with c=1.0). The next START uses 2.0.
// 6. Assert reset mid-job -> busy=0, done=0, ITER=0 next cycle. STATUS read while busy returns 32'h1.

Source files
------------

// File: rtl/mandel_mmio_engine.sv
// Memory-mapped Mandelbrot iteration engine: CPU stores c and max_iter, starts a job,
// polls STATUS, then reads the escape count. One z = z^2 + c step per clock in Q(32-FRAC).FRAC.
module mandel_mmio_engine #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          FRAC      = 28,
    parameter int          ITER_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_t;

    localparam logic signed [63:0] FOUR = 64'sd4 <<< FRAC;

    state_t              state_q, state_d;
    logic [31:0]         cx_q, cx_d, cy_q, cy_d;
    logic [ITER_W-1:0]   maxiter_q, maxiter_d, iter_q, iter_d;
    logic signed [31:0]  wcx_q, wcx_d, wcy_q, wcy_d;
    logic [ITER_W-1:0]   wmax_q, wmax_d, count_q, count_d;
    logic signed [31:0]  zr_q, zr_d, zi_q, zi_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic [2:0]          offset_s;
    logic                wr_s, start_s, escape_s;
    logic signed [63:0]  p_rr_s, p_ii_s, p_ri_s, sr_s, si_s, mag_s;
    logic                unused_s;

    assign hit      = (memaddr[31:5] == BASE_ADDR[31:5]);
    assign offset_s = memaddr[4:2];
    assign wr_s     = memwrite && hit;
    assign start_s  = wr_s && (offset_s == 3'd3) && writedata[0];
    assign busy     = busy_q;
    assign unused_s = ^memaddr[1:0];

    // Full-width products keep |z|^2 exact so the escape test never overflows.
    assign p_rr_s   = 64'(zr_q) * 64'(zr_q);
    assign p_ii_s   = 64'(zi_q) * 64'(zi_q);
    assign p_ri_s   = 64'(zr_q) * 64'(zi_q);
    assign sr_s     = p_rr_s >>> FRAC;
    assign si_s     = p_ii_s >>> FRAC;
    assign mag_s    = sr_s + si_s;
    assign escape_s = (mag_s > FOUR);

    // Combinational read mux for the register map
    always_comb begin
        rdata = 32'h0000_0000;
        if (hit) begin
            case (offset_s)
                3'd0:    rdata = cx_q;
                3'd1:    rdata = cy_q;
                3'd2:    rdata = 32'(maxiter_q);
                3'd3:    rdata = {30'd0, done_q, busy_q};
                3'd4:    rdata = 32'(iter_q);
                default: rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // Next-state logic: register writes plus the IDLE/ITER job sequencer
    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        maxiter_d = maxiter_q;
        iter_d    = iter_q;
        wcx_d     = wcx_q;
        wcy_d     = wcy_q;
        wmax_d    = wmax_q;
        count_d   = count_q;
        zr_d      = zr_q;
        zi_d      = zi_q;
        busy_d    = busy_q;
        done_d    = done_q;

        if (wr_s) begin
            case (offset_s)
                3'd0:    cx_d      = writedata;
                3'd1:    cy_d      = writedata;
                3'd2:    maxiter_d = writedata[ITER_W-1:0];
                default: cx_d      = cx_q;
            endcase
        end else begin
            cx_d = cx_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    wcx_d   = cx_q;
                    wcy_d   = cy_q;
                    wmax_d  = maxiter_q;
                    zr_d    = 32'sd0;
                    zi_d    = 32'sd0;
                    count_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_ITER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (escape_s) begin
                    iter_d  = count_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (count_q == wmax_q) begin
                    iter_d  = wmax_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    // (2*zr*zi)>>>FRAC done as a shift by FRAC-1 so the doubling cannot overflow
                    zr_d    = 32'(sr_s - si_s + 64'(wcx_q));
                    zi_d    = 32'((p_ri_s >>> (FRAC - 1)) + 64'(wcy_q));
                    count_d = count_q + ITER_W'(1);
                    state_d = S_ITER;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cx_q      <= 32'h0000_0000;
            cy_q      <= 32'h0000_0000;
            maxiter_q <= '0;
            iter_q    <= '0;
            wcx_q     <= 32'sd0;
            wcy_q     <= 32'sd0;
            wmax_q    <= '0;
            count_q   <= '0;
            zr_q      <= 32'sd0;
            zi_q      <= 32'sd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            maxiter_q <= maxiter_d;
            iter_q    <= iter_d;
            wcx_q     <= wcx_d;
            wcy_q     <= wcy_d;
            wmax_q    <= wmax_d;
            count_q   <= count_d;
            zr_q      <= zr_d;
            zi_q      <= zi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule
